// File: rtl/fetch_unit_if.sv
// fetch_unit_if: in-order instruction memory request/response channel.
interface fetch_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  modport master(output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave(input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with response buffer, redirect squashing and IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_f,
  input  logic          stall_d,
  input  logic          flush_d,
  input  logic          pc_src_e,
  input  logic [31:0]   pc_target_e,
  fetch_unit_if.master  imem,
  output logic [31:0]   instr_d,
  output logic [31:0]   pc_d,
  output logic [31:0]   pc_plus4_d,
  output logic          valid_d
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW+1:0] DEPTH = (AW+2)'(BUF_DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] pc_f;
  logic [AW:0] head, fill, tail, drop_cnt, count, unfilled;
  logic [31:0] buf_pc [BUF_DEPTH];
  logic [31:0] buf_instr [BUF_DEPTH];
  logic push, take, head_filled, bypass, load, pop;
  logic [31:0] next_pc, next_instr;
  // head..fill are filled entries, fill..tail await their response
  assign count       = tail - head;
  assign unfilled    = tail - fill;
  assign imem.req_valid = rst_n && !stall_f && !pc_src_e && ({1'b0, count} + {1'b0, drop_cnt} < DEPTH);
  assign imem.req_addr  = pc_f;
  assign push        = imem.req_valid && imem.req_ready;
  assign take        = imem.rsp_valid && drop_cnt == '0 && !pc_src_e;
  assign head_filled = head != fill;
  assign bypass      = !head_filled && take;
  assign load        = !stall_d && !flush_d;
  assign pop         = load && !pc_src_e && (head_filled || bypass);
  assign next_pc     = buf_pc[head[AW-1:0]];
  assign next_instr  = head_filled ? buf_instr[head[AW-1:0]] : imem.rsp_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f     <= RESET_PC;
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      drop_cnt <= '0;
    end else if (pc_src_e) begin
      pc_f     <= pc_target_e;
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      drop_cnt <= drop_cnt + unfilled - (AW+1)'(imem.rsp_valid);
    end else begin
      if (push) begin
        tail <= tail + ONE;
        pc_f <= pc_f + 32'd4;
      end
      if (imem.rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - ONE;
      if (take) fill <= fill + ONE;
      if (pop) head <= head + ONE;
    end
  end
  always_ff @(posedge clk) begin
    if (push) buf_pc[tail[AW-1:0]] <= pc_f;
    if (take) buf_instr[fill[AW-1:0]] <= imem.rsp_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= NOP;
      pc_d       <= '0;
      pc_plus4_d <= 32'd4;
      valid_d    <= 1'b0;
    end else if (pop) begin
      instr_d    <= next_instr;
      pc_d       <= next_pc;
      pc_plus4_d <= next_pc + 32'd4;
      valid_d    <= 1'b1;
    end else if (flush_d || load) begin
      instr_d <= NOP;
      valid_d <= 1'b0;
    end
  end
endmodule
